// File: rtl/floppy_byte_gen.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// floppy_byte_gen
//
// Turns the virtual floppy drive's byte clock and gap/header/data framing into
// the serial byte stream seen by the FDC read path. It builds the 6-byte ID
// field, streams sector payload from the disk-image sector buffer, appends the
// data-field CRC and fills everything else with the gap byte.
//
// Optional feature (macro FLOPPY_BYTE_GEN_CRC_ERR_EN): adds input crc_err.
// When crc_err is high at the first CRC byte of a field, the low CRC byte of
// that field is emitted with bit 0 inverted. The internal CRC is not altered.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   dclk_en      byte clock enable from the drive (>= 4 clk apart)
//   ready        drive ready; low forces the stream idle
//   track        track under head
//   side         head select
//   sector       sector under head
//   sector_hdr   ID field passing head
//   sector_data  data field passing head
//   size_code    ID size code (0=128 .. 3=1024)
//   buf_addr     byte address into the sector buffer
//   buf_sector   sector number being fetched
//   buf_rd       one-clk read strobe; buf_data valid the following clk
//   buf_data     sector buffer read data
//   crc_err      (optional) corrupt the low CRC byte of the current field
//   byte_out     current byte under head
//   byte_strobe  one-clk pulse, byte_out valid
//   byte_is_hdr  byte_out belongs to the ID field (including its CRC)
//   byte_is_data byte_out is payload
//   byte_is_crc  byte_out is a CRC byte (ID or data)
//   crc          running CRC-16/CCITT of the current field
// -----------------------------------------------------------------------------
module floppy_byte_gen #(
  parameter logic [7:0]  GAP_BYTE   = 8'h4E,
  parameter logic [15:0] CRC_PRESET = 16'hCDB4,
  parameter logic [7:0]  ID_MARK    = 8'hFE,
  parameter logic [7:0]  DATA_MARK  = 8'hFB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dclk_en,
  input  logic        ready,
  input  logic [6:0]  track,
  input  logic        side,
  input  logic [4:0]  sector,
  input  logic        sector_hdr,
  input  logic        sector_data,
  input  logic [1:0]  size_code,
  output logic [9:0]  buf_addr,
  output logic [4:0]  buf_sector,
  output logic        buf_rd,
  input  logic [7:0]  buf_data,
`ifdef FLOPPY_BYTE_GEN_CRC_ERR_EN
  input  logic        crc_err,
`endif
  output logic [7:0]  byte_out,
  output logic        byte_strobe,
  output logic        byte_is_hdr,
  output logic        byte_is_data,
  output logic        byte_is_crc,
  output logic [15:0] crc
);

  typedef enum logic [1:0] {ST_GAP, ST_HDR, ST_DATA, ST_DCRC} state_t;

  // CRC-16/CCITT, polynomial 0x1021, MSB first, one whole byte per call.
  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Field seeds: preset (three A1 syncs already folded) plus the address mark.
  localparam logic [15:0] ID_SEED   = crc_byte(CRC_PRESET, ID_MARK);
  localparam logic [15:0] DATA_SEED = crc_byte(CRC_PRESET, DATA_MARK);

  state_t      state_q, state_n;
  logic [2:0]  idx_q, idx_n;         // next ID-field byte to emit (1..5)
  logic [15:0] crc_q, crc_n;
  logic [7:0]  byte_q, byte_n;
  logic        hdr_q, hdr_n;
  logic        data_q, data_n;
  logic        crcf_q, crcf_n;
  logic        strobe_q, strobe_n;
  logic        rd_q, rd_n;
  logic        rd_d_q;               // buf_rd delayed: buf_data is valid now
  logic [9:0]  addr_q, addr_n;
  logic [4:0]  sec_q, sec_n;
  logic        hdr_prev_q, hdr_prev_n;
  logic        err_q, err_n;         // corrupt the coming low CRC byte
  logic [7:0]  pf_q;                 // prefetched payload byte
  logic        hdr_rise;
  logic        start_hdr;
  logic        err_in;

`ifdef FLOPPY_BYTE_GEN_CRC_ERR_EN
  assign err_in = crc_err;
`else
  assign err_in = 1'b0;
`endif

  // A header starts only on a rising sector_hdr, so a header window that is
  // already under way when ready returns is not emitted half-formed.
  assign hdr_rise = sector_hdr & ~hdr_prev_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    crc_n      = crc_q;
    byte_n     = byte_q;
    hdr_n      = hdr_q;
    data_n     = data_q;
    crcf_n     = crcf_q;
    strobe_n   = 1'b0;
    rd_n       = 1'b0;
    addr_n     = addr_q;
    sec_n      = sec_q;
    hdr_prev_n = hdr_prev_q;
    err_n      = err_q;
    start_hdr  = 1'b0;

    if (dclk_en) hdr_prev_n = sector_hdr;

    if (!ready) begin
      state_n = ST_GAP;
      byte_n  = GAP_BYTE;
      hdr_n   = 1'b0;
      data_n  = 1'b0;
      crcf_n  = 1'b0;
    end else if (dclk_en) begin
      strobe_n = 1'b1;
      byte_n   = GAP_BYTE;
      hdr_n    = 1'b0;
      data_n   = 1'b0;
      crcf_n   = 1'b0;

      case (state_q)
        ST_GAP: begin
          if (hdr_rise) start_hdr = 1'b1;
        end

        ST_HDR: begin
          if (!sector_hdr) begin
            state_n = ST_GAP;           // truncated ID field
          end else begin
            hdr_n = 1'b1;
            idx_n = idx_q + 3'd1;
            case (idx_q)
              3'd1: begin
                byte_n = {7'b0, side};
                crc_n  = crc_byte(crc_q, {7'b0, side});
              end
              3'd2: begin
                byte_n = {3'b0, sector};
                crc_n  = crc_byte(crc_q, {3'b0, sector});
              end
              3'd3: begin
                byte_n = {6'b0, size_code};
                crc_n  = crc_byte(crc_q, {6'b0, size_code});
              end
              3'd4: begin
                byte_n = crc_q[15:8];
                crcf_n = 1'b1;
                err_n  = err_in;
              end
              3'd5: begin
                byte_n = crc_q[7:0] ^ {7'b0, err_q};
                crcf_n = 1'b1;
                if (sector_data) begin
                  // Latch the sector and issue the byte-0 prefetch now.
                  state_n = ST_DATA;
                  crc_n   = DATA_SEED;
                  sec_n   = sector;
                  addr_n  = '0;
                  rd_n    = 1'b1;
                end else begin
                  state_n = ST_GAP;
                end
              end
              default: begin
                hdr_n   = 1'b0;
                state_n = ST_GAP;
              end
            endcase
          end
        end

        ST_DATA: begin
          if (sector_data) begin
            byte_n = pf_q;
            data_n = 1'b1;
            crc_n  = crc_byte(crc_q, pf_q);
            addr_n = addr_q + 10'd1;
            rd_n   = 1'b1;
          end else begin
            state_n = ST_DCRC;
            byte_n  = crc_q[15:8];
            crcf_n  = 1'b1;
            err_n   = err_in;
          end
        end

        ST_DCRC: begin
          if (hdr_rise) begin
            start_hdr = 1'b1;           // header wins over the low CRC byte
          end else begin
            byte_n  = crc_q[7:0] ^ {7'b0, err_q};
            crcf_n  = 1'b1;
            state_n = ST_GAP;
          end
        end

        default: state_n = ST_GAP;
      endcase

      if (start_hdr) begin
        state_n = ST_HDR;
        idx_n   = 3'd1;
        byte_n  = {1'b0, track};
        hdr_n   = 1'b1;
        data_n  = 1'b0;
        crcf_n  = 1'b0;
        crc_n   = crc_byte(ID_SEED, {1'b0, track});
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_GAP;
      idx_q      <= '0;
      crc_q      <= CRC_PRESET;
      byte_q     <= GAP_BYTE;
      hdr_q      <= 1'b0;
      data_q     <= 1'b0;
      crcf_q     <= 1'b0;
      strobe_q   <= 1'b0;
      rd_q       <= 1'b0;
      rd_d_q     <= 1'b0;
      addr_q     <= '0;
      sec_q      <= '0;
      hdr_prev_q <= 1'b0;
      err_q      <= 1'b0;
      pf_q       <= '0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      crc_q      <= crc_n;
      byte_q     <= byte_n;
      hdr_q      <= hdr_n;
      data_q     <= data_n;
      crcf_q     <= crcf_n;
      strobe_q   <= strobe_n;
      rd_q       <= rd_n;
      rd_d_q     <= rd_q;
      addr_q     <= addr_n;
      sec_q      <= sec_n;
      hdr_prev_q <= hdr_prev_n;
      err_q      <= err_n;
      if (rd_d_q) pf_q <= buf_data;
    end
  end

  assign buf_addr     = addr_q;
  assign buf_sector   = sec_q;
  assign buf_rd       = rd_q;
  assign byte_out     = byte_q;
  assign byte_strobe  = strobe_q;
  assign byte_is_hdr  = hdr_q;
  assign byte_is_data = data_q;
  assign byte_is_crc  = crcf_q;
  assign crc          = crc_q;

endmodule

// File: tb/tb_floppy_byte_gen.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_floppy_byte_gen
//
// Directed bench for floppy_byte_gen. Each scenario drives byte-clock slots
// and queues the bytes the stream must carry; a background compare loop pops
// one expectation per byte_strobe. CRC expectations come from a whole-message
// CRC-CCITT (init FFFF) over sync bytes, mark and field bytes.
// -----------------------------------------------------------------------------
module tb_floppy_byte_gen;

  localparam logic [7:0] GAP = 8'h4E;

  logic        clk = 1'b0;
  logic        reset;
  logic        dclk_en;
  logic        ready;
  logic [6:0]  track;
  logic        side;
  logic [4:0]  sector;
  logic        sector_hdr;
  logic        sector_data;
  logic [1:0]  size_code;
  logic [9:0]  buf_addr;
  logic [4:0]  buf_sector;
  logic        buf_rd;
  logic [7:0]  buf_data = 8'h00;
  logic [7:0]  byte_out;
  logic        byte_strobe;
  logic        byte_is_hdr;
  logic        byte_is_data;
  logic        byte_is_crc;
  logic [15:0] crc;
  bit          err_inj = 1'b0;
`ifdef FLOPPY_BYTE_GEN_CRC_ERR_EN
  logic        crc_err;
  assign crc_err = err_inj;
`endif

  floppy_byte_gen dut (
    .clk(clk), .reset(reset), .dclk_en(dclk_en), .ready(ready),
    .track(track), .side(side), .sector(sector),
    .sector_hdr(sector_hdr), .sector_data(sector_data), .size_code(size_code),
    .buf_addr(buf_addr), .buf_sector(buf_sector), .buf_rd(buf_rd),
    .buf_data(buf_data),
`ifdef FLOPPY_BYTE_GEN_CRC_ERR_EN
    .crc_err(crc_err),
`endif
    .byte_out(byte_out), .byte_strobe(byte_strobe),
    .byte_is_hdr(byte_is_hdr), .byte_is_data(byte_is_data),
    .byte_is_crc(byte_is_crc), .crc(crc)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] msg_t[$];
  typedef struct {
    logic [7:0]  b;
    logic [2:0]  flags;   // {hdr, data, crc}
    logic [15:0] crc;
    logic        chk_sec;
    logic [4:0]  sec;
  } exp_t;

  exp_t exp_q[$];
  msg_t field_msg;
  int   checks = 0;
  int   errors = 0;
  int   rd_count = 0;

  // CRC-16/CCITT-FALSE over a complete message, bit-serial from FFFF.
  function automatic logic [15:0] crc_of(input msg_t m);
    logic [15:0] c;
    logic [7:0]  v;
    c = 16'hFFFF;
    foreach (m[i]) begin
      v = m[i];
      for (int b = 7; b >= 0; b--) begin
        c = (c[15] ^ v[b]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Sector buffer image: sector 1 holds addr[7:0], others are offset by 8/sector.
  function automatic logic [7:0] buf_content(input logic [4:0] s, input logic [9:0] a);
    logic [4:0] s1;
    s1 = s - 5'd1;
    return a[7:0] + {s1, 3'b000};
  endfunction

  always @(posedge clk) if (buf_rd) buf_data <= buf_content(buf_sector, buf_addr);
  always @(posedge clk) if (buf_rd) rd_count <= rd_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic [2:0] f, input logic [15:0] c,
                      input logic cs, input logic [4:0] s);
    exp_t e;
    e.b = b; e.flags = f; e.crc = c; e.chk_sec = cs; e.sec = s;
    exp_q.push_back(e);
  endtask

  task automatic compare_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && byte_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {31'b0, byte_strobe}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("byte_out", byte_out, e.b);
          check("flags", {byte_is_hdr, byte_is_data, byte_is_crc}, e.flags);
          check("crc", crc, e.crc);
          if (e.chk_sec) check("buf_sector", buf_sector, e.sec);
        end
      end
    end
  endtask

  task automatic start_field(input logic [7:0] mark);
    field_msg.delete();
    repeat (3) field_msg.push_back(8'hA1);
    if (mark != 8'h00) field_msg.push_back(mark);
  endtask

  // One byte-clock slot: framing valid with dclk_en, then 4 idle clocks.
  task automatic tick(input bit h, input bit d);
    @(negedge clk);
    sector_hdr  = h;
    sector_data = d;
    dclk_en     = 1'b1;
    @(negedge clk);
    dclk_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] id_byte(input int k);
    case (k)
      0:       return {1'b0, track};
      1:       return {7'b0, side};
      2:       return {3'b0, sector};
      default: return {6'b0, size_code};
    endcase
  endfunction

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      push(GAP, 3'b000, crc_of(field_msg), 1'b0, 5'd0);
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic id_field(input logic [6:0] t, input logic s, input logic [4:0] sec,
                          input logic [1:0] sz, input bit then_data);
    logic [15:0] ic;
    track = t; side = s; sector = sec; size_code = sz;
    start_field(8'hFE);
    for (int k = 0; k < 4; k++) begin
      field_msg.push_back(id_byte(k));
      push(id_byte(k), 3'b100, crc_of(field_msg), 1'b0, 5'd0);
      tick(1'b1, 1'b0);
    end
    ic = crc_of(field_msg);
    push(ic[15:8], 3'b101, ic, 1'b0, 5'd0);
    tick(1'b1, 1'b0);
    if (then_data) start_field(8'hFB);
    push(ic[7:0] ^ {7'b0, err_inj}, 3'b101, crc_of(field_msg), 1'b0, 5'd0);
    tick(1'b1, then_data);
  endtask

  task automatic data_field(input int n, input logic [4:0] s, input int first);
    logic [7:0] b;
    for (int k = first; k < first + n; k++) begin
      b = buf_content(s, 10'(k));
      field_msg.push_back(b);
      push(b, 3'b010, crc_of(field_msg), 1'b1, s);
      tick(1'b0, 1'b1);
    end
  endtask

  task automatic dcrc(input bit cut);
    logic [15:0] dc;
    dc = crc_of(field_msg);
    push(dc[15:8], 3'b001, dc, 1'b0, 5'd0);
    tick(1'b0, 1'b0);
    if (!cut) begin
      push(dc[7:0] ^ {7'b0, err_inj}, 3'b001, dc, 1'b0, 5'd0);
      tick(1'b0, 1'b0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    msg_t pin;
    int   rd_base;

    reset = 1'b1; dclk_en = 1'b0; ready = 1'b1;
    track = '0; side = 1'b0; sector = '0; size_code = '0;
    sector_hdr = 1'b0; sector_data = 1'b0;
    fork compare_loop(); join_none

    // Pin the CRC model against known values.
    pin.delete();
    for (int i = 0; i < 9; i++) pin.push_back(8'h31 + 8'(i));
    check("pin_crc_123456789", crc_of(pin), 16'h29B1);
    start_field(8'h00);
    check("pin_crc_a1a1a1", crc_of(field_msg), 16'hCDB4);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_byte_out", byte_out, 8'h4E);
    check("rst_strobe", byte_strobe, 1'b0);
    check("rst_flags", {byte_is_hdr, byte_is_data, byte_is_crc}, 3'b000);
    check("rst_buf_addr", buf_addr, 10'd0);
    check("rst_buf_sector", buf_sector, 5'd0);
    check("rst_buf_rd", buf_rd, 1'b0);
    check("rst_crc", crc, 16'hCDB4);
    reset = 1'b0;

    gap(3);

    // ID field only: 03 00 01 02 CRChi CRClo, then gap.
    id_field(7'd3, 1'b0, 5'd1, 2'd2, 1'b0);
    gap(2);

    // ID field + 256-byte data field from sector 1.
    rd_base = rd_count;
    id_field(7'd3, 1'b0, 5'd1, 2'd2, 1'b1);
    data_field(256, 5'd1, 0);
    dcrc(1'b0);
    gap(1);
    check("rd_count_256", rd_count - rd_base, 257);
    check("buf_addr_after_256", buf_addr, 10'd256);
    check("buf_sector_after_256", buf_sector, 5'd1);

    // Sector input changes mid-data: buf_sector must stay latched.
    id_field(7'd10, 1'b1, 5'd2, 2'd3, 1'b1);
    data_field(4, 5'd2, 0);
    sector = 5'd7;
    data_field(4, 5'd2, 4);
    check("buf_sector_latched", buf_sector, 5'd2);
    dcrc(1'b0);
    gap(2);

    // ID field truncated after byte 2.
    track = 7'd20; side = 1'b1; sector = 5'd9; size_code = 2'd1;
    start_field(8'hFE);
    for (int k = 0; k < 3; k++) begin
      field_msg.push_back(id_byte(k));
      push(id_byte(k), 3'b100, crc_of(field_msg), 1'b0, 5'd0);
      tick(1'b1, 1'b0);
    end
    gap(2);

    // ready drops for 3 byte clocks in mid-header.
    track = 7'd40; side = 1'b0; sector = 5'd4; size_code = 2'd2;
    start_field(8'hFE);
    for (int k = 0; k < 2; k++) begin
      field_msg.push_back(id_byte(k));
      push(id_byte(k), 3'b100, crc_of(field_msg), 1'b0, 5'd0);
      tick(1'b1, 1'b0);
    end
    ready = 1'b0;
    repeat (3) tick(1'b1, 1'b0);
    check("ready_low_buf_rd", buf_rd, 1'b0);
    ready = 1'b1;
    push(GAP, 3'b000, crc_of(field_msg), 1'b0, 5'd0);
    tick(1'b1, 1'b0);
    gap(1);
    id_field(7'd40, 1'b0, 5'd4, 2'd2, 1'b0);
    gap(1);

    // Header right after the data CRC high byte: low byte is dropped.
    id_field(7'd5, 1'b1, 5'd6, 2'd0, 1'b1);
    data_field(4, 5'd6, 0);
    dcrc(1'b1);
    id_field(7'd5, 1'b1, 5'd7, 2'd0, 1'b0);
    gap(2);

`ifdef FLOPPY_BYTE_GEN_CRC_ERR_EN
    // Injected data CRC error: low byte xor 01, crc output unaffected.
    id_field(7'd8, 1'b0, 5'd2, 2'd1, 1'b1);
    err_inj = 1'b1;
    data_field(3, 5'd2, 0);
    dcrc(1'b0);
    err_inj = 1'b0;
    gap(1);
`endif

    // Asynchronous reset while data byte 100 is being emitted.
    id_field(7'd3, 1'b0, 5'd1, 2'd2, 1'b1);
    data_field(100, 5'd1, 0);
    @(negedge clk);
    sector_hdr = 1'b0; sector_data = 1'b1; dclk_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_byte_out", byte_out, 8'h4E);
    check("midrst_buf_addr", buf_addr, 10'd0);
    check("midrst_strobe", byte_strobe, 1'b0);
    check("midrst_crc", crc, 16'hCDB4);
    check("midrst_flags", {byte_is_hdr, byte_is_data, byte_is_crc}, 3'b000);
    @(negedge clk);
    dclk_en = 1'b0; sector_data = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_field(8'h00);
    gap(2);
    id_field(7'd3, 1'b0, 5'd3, 2'd2, 1'b1);
    data_field(8, 5'd3, 0);
    dcrc(1'b0);
    gap(2);
    check("buf_addr_after_restart", buf_addr, 10'd8);

    repeat (5) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/floppy_byte_gen.md
Name: floppy_byte_gen

Overview:
- Downstream consumer of the virtual floppy drive model. Turns its byte clock and its gap/header/data framing into the serial byte stream the FDC read path sees.
- Builds the 6-byte ID field (track, side, sector, size, CRC hi, CRC lo) and fetches sector payload from the disk-image sector buffer.
- Appends the data-field CRC and fills gaps with 0x4E.
- Runs the CRC-16/CCITT engine used by the FDC for CRC checking.

Parameters:
- GAP_BYTE, 8'h4E, filler byte emitted outside header/data/CRC.
- CRC_PRESET, 16'hCDB4, CRC state after the three A1 sync bytes; reloaded at the start of each field.
- ID_MARK, 8'hFE, ID address mark; folded into the CRC, not emitted.
- DATA_MARK, 8'hFB, data address mark; folded into the CRC, not emitted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dclk_en  in  1  byte clock enable from drive; spacing guaranteed >= 4 clk
- ready  in  1  drive ready
- track  in  7  track under head
- side  in  1  head select
- sector  in  5  sector under head
- sector_hdr  in  1  ID field passing head
- sector_data  in  1  data field passing head
- size_code  in  2  ID size code (0=128 .. 3=1024)
- buf_addr  out  10  byte address into sector buffer
- buf_sector  out  5  sector number being fetched
- buf_rd  out  1  one-clk read strobe; buffer data valid next clk
- buf_data  in  8  buffer read data
- byte_out  out  8  current byte under head
- byte_strobe  out  1  one-clk pulse, byte_out valid
- byte_is_hdr  out  1  byte_out belongs to ID field (incl. CRC)
- byte_is_data  out  1  byte_out is payload
- byte_is_crc  out  1  byte_out is a CRC byte (ID or data)
- crc  out  16  running CRC of current field

Behaviour:
- Reset (async, any time, including mid-field):
  - byte_out=GAP_BYTE, all strobes/flags 0.
  - buf_addr=0, buf_sector=0, crc=CRC_PRESET, state=GAP, byte index=0.
- All activity is qualified by dclk_en. Framing inputs are sampled on the dclk_en cycle; byte_out and the flags register then, and byte_strobe pulses on the following clk (1 clk latency).
- ready=0: state forced to GAP, byte_strobe held 0, buf_rd 0. Resumption is clean at the next sector_hdr rising.
- States: GAP, HDR, DATA, DCRC.
- GAP:
  - Emits GAP_BYTE, flags 0.
  - On a dclk_en with sector_hdr=1 -> HDR, index 0, crc = CRC_PRESET updated with ID_MARK, and byte 0 is emitted in that same sample.
- HDR, by index:
  - Bytes 0..3: {1'b0,track}, {7'b0,side}, {3'b0,sector}, {6'b0,size_code}; each is folded into crc.
  - Bytes 4,5: crc[15:8], crc[7:0], frozen at the value after byte 3. byte_is_crc=1.
  - After byte 5: sector_data=1 -> DATA, otherwise GAP.
  - sector_hdr dropping before byte 5: truncate and go to GAP.
- Entry into DATA:
  - crc = CRC_PRESET updated with DATA_MARK.
  - buf_sector=sector, buf_addr=0.
  - buf_rd is issued on the clk after the HDR->DATA transition, so byte 0 is prefetched.
- DATA:
  - Each dclk_en emits the prefetched byte and folds it into crc.
  - Then buf_addr increments (10-bit, wraps 1023->0) and buf_rd pulses to prefetch the next byte.
  - When sector_data samples 0 -> DCRC, and the first CRC byte is emitted in that same sample.
- DCRC: two bytes crc[15:8] then crc[7:0] (byte_is_crc=1, byte_is_data=0), then GAP.
- sector_hdr=1 sampled in DCRC (header gap < 2): header wins; the CRC is truncated and the block enters HDR.
- CRC:
  - CRC-16/CCITT, polynomial 0x1021, MSB first, no reflection, no final xor.
  - Byte-wide update in a single clk.
  - crc output shows the running value.
- An index pulse is not an input; framing alone drives the FSM.
- A sector change inside DATA is ignored: buf_sector is latched only on entry to DATA.

Optional Feature:
- FLOPPY_BYTE_GEN_CRC_ERR_EN defined:
  - Adds input crc_err (1 bit).
  - When crc_err=1 at the first DCRC or HDR CRC byte, the low CRC byte is emitted xor 8'h01; the internal crc is unchanged.
  - Used by the FDC test bench to exercise CRC-error status.
- Undefined: no port, CRC bytes always correct.

Test Plan:
- Reset mid-DATA: assert reset during byte 100 -> byte_out=8'h4E, buf_addr=0, byte_strobe=0 within 0 clk (async); next sector_hdr restarts cleanly.
- ID field: track=7'd3, side=0, sector=5'd1, size_code=2, hdr window 6 bytes -> bytes 03 00 01 02, then CRC hi/lo equal to the model CRC-CCITT(FFFF) over A1 A1 A1 FE 03 00 01 02, with byte_is_hdr=1 for all 6.
- Data 256 bytes: buffer holds addr[7:0] -> byte_out 00..FF, buf_sector=1, buf_rd count=256 (plus 1 prefetch); the two CRC bytes match the model over A1 A1 A1 FB 00..FF; then 4E.
- ready drop: ready=0 for 3 dclk_en in mid-header -> no byte_strobe, state GAP; next header emits correctly.
- Header follows data after 1 gap byte -> only the DCRC hi byte is emitted, then HDR byte 0 with crc reloaded.
- With FLOPPY_BYTE_GEN_CRC_ERR_EN and crc_err=1: data CRC low byte = model^8'h01; without the macro, the crc_err port does not exist (build check).
